// File: rtl/ram_request_scheduler.sv
// Request scheduler in front of the SDRAM controller: queues CPU requests in a small
// FIFO, issues them one at a time as level strobes and injects periodic refreshes.
module ram_request_scheduler #(
    parameter int ADDR_W           = 22,
    parameter int DATA_W           = 16,
    parameter int DEPTH            = 4,
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              read_rq,
    output logic              write_rq,
    output logic              refresh_rq,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              op_trigger,
    output logic              refresh_missed,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REF_W = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_INTERVAL - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BUSY     = 2'd1;
    localparam logic [1:0] ST_REF_WAIT = 2'd2;

    // Handshake: a request is taken on any clock edge where req_valid && req_ready.
    logic              fifo_write [DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [1:0]        state;
    logic [REF_W-1:0]  ref_cnt;
    logic              refresh_pending;
    logic              ref_due;
    logic              take_ref;
    logic              push;
    logic              pop;

    assign req_ready = (count != CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == ST_BUSY) && op_trigger;
    assign dbg_state = state;

    // A refresh falling due this very cycle already outranks a queued request.
    assign ref_due  = (ref_cnt == '0);
    assign take_ref = (state == ST_IDLE) && (refresh_pending || ref_due);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= req_write;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt         <= REF_RELOAD;
            refresh_pending <= 1'b0;
            refresh_missed  <= 1'b0;
        end else begin
            ref_cnt <= ref_due ? REF_RELOAD : ref_cnt - 1'b1;
            if (take_ref)     refresh_pending <= 1'b0;
            else if (ref_due) refresh_pending <= 1'b1;
            if (ref_due && refresh_pending) refresh_missed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            read_rq    <= 1'b0;
            write_rq   <= 1'b0;
            refresh_rq <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_ref) begin
                        refresh_rq <= 1'b1;
                        state      <= ST_REF_WAIT;
                    end else if (count != '0) begin
                        mem_addr  <= fifo_addr[rd_ptr];
                        mem_wdata <= fifo_wdata[rd_ptr];
                        read_rq   <= !fifo_write[rd_ptr];
                        write_rq  <= fifo_write[rd_ptr];
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (op_trigger) begin
                        read_rq  <= 1'b0;
                        write_rq <= 1'b0;
                        if (read_rq) begin
                            resp_valid <= 1'b1;
                            resp_data  <= rd_data;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_REF_WAIT: begin
                    if (op_trigger) begin
                        refresh_rq <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_request_scheduler.sv
// Bench for ram_request_scheduler: a controller model answers each strobe and a
// scoreboard checks issue order, addresses, write data and returned read data.
module tb_ram_request_scheduler;
    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int REF_INT = 60;

    typedef struct packed {
        logic              w;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } op_t;

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                lat;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              read_rq, write_rq, refresh_rq;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;
    logic              op_trigger;
    logic              refresh_missed;
    logic [1:0]        dbg_state;
    logic              ctrl_trig = 1'b0;
    logic              stray_trig = 1'b0;

    assign op_trigger = ctrl_trig | stray_trig;

    ram_request_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .REFRESH_INTERVAL(REF_INT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .read_rq(read_rq), .write_rq(write_rq), .refresh_rq(refresh_rq),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rd_data(rd_data), .op_trigger(op_trigger),
        .refresh_missed(refresh_missed), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    op_t               exp_q[$];
    logic [DATA_W-1:0] resp_q[$];
    int                op_log[$];
    int                n_vec = 0;
    int                n_err = 0;
    int                ctrl_lat = 3;
    bit                in_op = 0;
    bit                just_trig = 0;
    bit                cur_read = 0;
    int                op_cnt = 0;
    int                last_len = 0;
    int                ref_seen = 0;
    int                resp_seen = 0;
    op_t               cur;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event did not match expectation", name);
    endtask

    // Controller model: answers each strobe ctrl_lat cycles after first seeing it.
    initial begin
        forever begin
            @(negedge clk);
            ctrl_trig = 1'b0;
            if (!rst_n) begin
                in_op = 0;
                just_trig = 0;
                continue;
            end
            chk("rq_onehot", 64'(int'(read_rq) + int'(write_rq) + int'(refresh_rq) <= 1), 64'd1);
            if (just_trig) begin
                chk("gap_after_op", {read_rq, write_rq, refresh_rq}, 0);
                just_trig = 0;
            end else if (!in_op && (read_rq || write_rq || refresh_rq)) begin
                in_op = 1;
                op_cnt = 0;
                cur_addr = mem_addr;
                cur_wdata = mem_wdata;
                cur_read = read_rq;
                cur = '0;
                if (refresh_rq) begin
                    ref_seen++;
                    op_log.push_back(2);
                end else begin
                    op_log.push_back(write_rq ? 1 : 0);
                    if (exp_q.size() == 0) flag("unexpected_issue");
                    else begin
                        cur = exp_q.pop_front();
                        chk("issue_kind", write_rq, cur.w);
                        chk("mem_addr", mem_addr, cur.addr);
                        if (cur.w) chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                end
            end else if (in_op) begin
                if (!(read_rq || write_rq || refresh_rq)) begin
                    flag("rq_dropped_early");
                    in_op = 0;
                end else begin
                    chk("mem_addr_stable", mem_addr, cur_addr);
                    chk("mem_wdata_stable", mem_wdata, cur_wdata);
                    op_cnt++;
                end
            end
            if (in_op && op_cnt >= ctrl_lat) begin
                ctrl_trig = 1'b1;
                in_op = 0;
                just_trig = 1;
                last_len = op_cnt + 1;
                if (cur_read) begin
                    rd_data = cur.rdata;
                    resp_q.push_back(cur.rdata);
                end else begin
                    rd_data = DATA_W'($urandom);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                resp_seen++;
                if (resp_q.size() == 0) flag("unexpected_resp");
                else chk("resp_data", resp_data, resp_q.pop_front());
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_try(input op_t op, output bit acc);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = op.w;
        req_addr  = op.addr;
        req_wdata = op.wdata;
        #1;
        acc = req_ready;
        if (acc) exp_q.push_back(op);
    endtask

    task automatic push_wait(input op_t op, output int tries);
        bit acc;
        tries = 0;
        for (int i = 0; i < 100; i++) begin
            push_try(op, acc);
            tries++;
            if (acc) return;
        end
        flag("push_timeout");
    endtask

    task automatic idle_in();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && resp_q.size() == 0 && !in_op && !just_trig) begin
                repeat (3) @(negedge clk);
                return;
            end
        end
        flag("drain_timeout");
    endtask

    task automatic wait_refresh();
        int r0 = ref_seen;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (ref_seen != r0) return;
        end
        flag("refresh_timeout");
    endtask

    vec_t vecs[8];
    bit   acc;
    int   tries, acc_n, r0;
    op_t  op;

    initial begin
        vecs[0] = '{1'b0, 22'h000000, 16'h0000, 16'h1234, 0};
        vecs[1] = '{1'b1, 22'h3FFFFF, 16'hFFFF, 16'h0000, 1};
        vecs[2] = '{1'b0, 22'h3FFFFF, 16'h0000, 16'hFFFF, 2};
        vecs[3] = '{1'b1, 22'h000000, 16'h0000, 16'h0000, 0};
        vecs[4] = '{1'b0, 22'h2AAAAA, 16'h5555, 16'h0000, 4};
        vecs[5] = '{1'b1, 22'h155555, 16'hA5A5, 16'h0000, 3};
        vecs[6] = '{1'b0, 22'h0ABCDE, 16'h0000, 16'h8001, 1};
        vecs[7] = '{1'b1, 22'h123456, 16'h7FFE, 16'h0000, 5};

        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rd_data   = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rq", {read_rq, write_rq, refresh_rq}, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_missed", refresh_missed, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Single read with a three-cycle controller delay.
        ctrl_lat = 3;
        push_try('{1'b0, 22'h00123, 16'h0000, 16'hBEEF}, acc);
        chk("single_accept", acc, 1);
        idle_in();
        chk("single_rq_not_yet", read_rq, 0);
        @(negedge clk);
        chk("single_rq_latency", read_rq, 1);
        r0 = resp_seen;
        drain();
        chk("single_resp_count", resp_seen - r0, 1);
        chk("single_rq_cycles", last_len, 4);
        chk("single_fifo_empty", req_ready, 1);

        // Table vectors, then a random batch.
        r0 = resp_seen;
        for (int i = 0; i < 8; i++) begin
            ctrl_lat = vecs[i].lat;
            push_wait('{vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].rdata}, tries);
        end
        idle_in();
        drain();
        chk("table_resp_count", resp_seen - r0, 4);
        for (int i = 0; i < 8; i++) begin
            op = '{1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom)};
            ctrl_lat = $urandom_range(0, 4);
            push_wait(op, tries);
        end
        idle_in();
        drain();

        // Completion pulse while idle must be ignored.
        for (int i = 0; i < 100; i++) begin
            if (!refresh_rq && !in_op) break;
            @(negedge clk);
        end
        stray_trig = 1'b1;
        @(negedge clk);
        stray_trig = 1'b0;
        chk("idle_trigger_ignored", {read_rq, write_rq, resp_valid}, 0);
        drain();

        // Back-pressure: five writes with the controller stalled.
        ctrl_lat = 1000;
        acc_n = 0;
        for (int i = 0; i < 5; i++) begin
            push_try('{1'b1, ADDR_W'(32'h100 + i), DATA_W'(32'hA000 + i), 16'h0000}, acc);
            acc_n += int'(acc);
        end
        idle_in();
        chk("fill_accepted", acc_n, DEPTH);
        chk("fill_not_ready", req_ready, 0);
        ctrl_lat = 2;
        drain();
        chk("fill_ready_after", req_ready, 1);

        // Push blocked at full, accepted right after a completion frees a slot.
        ctrl_lat = 1000;
        for (int i = 0; i < 4; i++) begin
            push_try('{1'($urandom_range(0, 1)), ADDR_W'(32'h200 + i), DATA_W'(32'hB000 + i),
                       DATA_W'(32'hC000 + i)}, acc);
            chk("full_fill_accept", acc, 1);
        end
        ctrl_lat = 0;
        push_wait('{1'b0, 22'h000204, 16'h0000, 16'hC004}, tries);
        chk("full_push_blocked", tries > 1, 1);
        idle_in();
        chk("full_again", req_ready, 0);
        ctrl_lat = 1;
        drain();

        // Refresh falling due during a read is served before the next read.
        repeat (5) @(negedge clk);
        wait_refresh();
        repeat (50) @(negedge clk);
        ctrl_lat = 15;
        op_log.delete();
        push_try('{1'b0, 22'h0001A0, 16'h0000, 16'h1111}, acc);
        push_try('{1'b0, 22'h0001A1, 16'h0000, 16'h2222}, acc);
        idle_in();
        drain();
        chk("prio_ops", op_log.size(), 3);
        if (op_log.size() == 3) begin
            chk("prio_first_read", op_log[0], 0);
            chk("prio_refresh_next", op_log[1], 2);
            chk("prio_second_read", op_log[2], 0);
        end

        // Refresh held unanswered across two more due points.
        chk("missed_before", refresh_missed, 0);
        ctrl_lat = 1000;
        wait_refresh();
        repeat (130) @(negedge clk);
        chk("missed_set", refresh_missed, 1);
        chk("missed_rq_held", refresh_rq, 1);
        ctrl_lat = 0;
        drain();
        chk("missed_sticky", refresh_missed, 1);

        // Reset while a write is outstanding with three more queued.
        ctrl_lat = 1000;
        for (int i = 0; i < 4; i++)
            push_try('{1'b1, ADDR_W'(32'h300 + i), DATA_W'(32'hD000 + i), 16'h0000}, acc);
        idle_in();
        for (int i = 0; i < 50; i++) begin
            if (write_rq) break;
            @(negedge clk);
        end
        chk("reset_write_active", write_rq, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_rq_cleared", {read_rq, write_rq, refresh_rq}, 0);
        chk("reset_ready", req_ready, 1);
        exp_q.delete();
        resp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_missed_cleared", refresh_missed, 0);
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc_n += int'(read_rq || write_rq);
        end
        chk("reset_no_issue", acc_n, 0);
        ctrl_lat = 2;
        r0 = resp_seen;
        push_try('{1'b0, 22'h0003FF, 16'h0000, 16'h4242}, acc);
        idle_in();
        drain();
        chk("reset_new_read", resp_seen - r0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
